branch_resolve: RTL and testbench
=================================

// Module: branch_resolve
// PURPOSE
//  Consumer of the 5-bit compare flag bus {eq, ne, lt, gt, zero} from the register comparator.
//  Decides branch taken/not-taken from a condition code and computes the target PC.
//  Redirects fetch via a valid/ready handshake, then holds flush for a fixed window.
//  Sits at the end of the decode/execute boundary of the 16-bit MIPS pipeline.
// PARAMETERS
//  PC_W          16  PC width; word addressed, arithmetic modulo 2^PC_W
//  OFF_W          8  branch offset width, two's complement, sign-extended to PC_W
//  FLUSH_CYCLES   2  cycles flush stays high after the redirect handshake (>=1)
//  CNT_W         16  width of the saturating taken counter
// PORTS
//  clk             in   1       clock, all state updates on rising edge
//  rst             in   1       synchronous, active-high reset
//  br_valid        in   1       branch request present
//  br_ready        out  1       block can accept a request (IDLE only)
//  br_cond         in   3       condition code (see BEHAVIOUR)
//  br_pc           in   PC_W    PC of the branch instruction
//  br_offset       in   OFF_W   signed offset relative to br_pc+1
//  compare_in      in   5       {eq, ne, lt, gt, zero}, sampled on accept cycle only
//  resolved_valid  out  1       one-cycle pulse: a branch was resolved
//  resolved_taken  out  1       outcome, valid with resolved_valid
//  redirect_valid  out  1       target PC offered to fetch
//  redirect_ready  in   1       fetch accepts redirect
//  redirect_pc     out  PC_W    branch target, stable while redirect_valid
//  flush           out  1       kill younger instructions
//  taken_count     out  CNT_W   saturating count of taken branches
// BEHAVIOUR
//  Reset: state=IDLE; resolved_valid, resolved_taken, redirect_valid and flush=0;
//   redirect_pc=0; taken_count=0. rst overrides every state, including mid-redirect/flush.
//  Cond codes: 0 BEQ=eq, 1 BNE=ne, 2 BLT=lt, 3 BGT=gt, 4 BEQZ=zero, 5 BLE=eq|lt,
//   6 BGE=eq|gt, 7 JMP=1 (flags ignored).
//  Accept: br_valid & br_ready in cycle N. Condition evaluated from compare_in in cycle N.
//   target = br_pc + 1 + sext(br_offset), truncated to PC_W bits (wraps).
//  N+1: resolved_valid=1 for exactly one cycle; resolved_taken=outcome.
//  Not taken: remain IDLE; br_ready stays 1, so back-to-back accepts every cycle are allowed.
//  Taken: N+1 state=REDIRECT: redirect_valid=1, redirect_pc=target, flush=1, br_ready=0.
//   redirect_pc must not change until handshake. Hold indefinitely while redirect_ready=0.
//   taken_count increments at N+1 and saturates at all-ones.
//  On redirect_valid & redirect_ready: next state FLUSH, redirect_valid=0.
//   flush stays 1 for exactly FLUSH_CYCLES further cycles (down-counter), then IDLE.
//  br_ready = (state==IDLE). flush = (state!=IDLE). Outputs are registered or decoded from state;
//   none is combinational from inputs.
//  br_valid while not IDLE: ignored, no accept. Requester must hold the request.
//  redirect_ready while not in REDIRECT: ignored.
//  States: IDLE -> (taken accept) REDIRECT -> (ready) FLUSH -> (count==0) IDLE;
//   IDLE -> (not-taken accept) IDLE.
// STRUCTURE
//  Shared package: cond-code localparams (COND_BEQ..COND_JMP), flag bit indices
//   (CMP_EQ=4, CMP_NE=3, CMP_LT=2, CMP_GT=1, CMP_ZERO=0), state encodings.
//  One sub-module: branch_cond_eval (combinational cond x flags -> taken).
//  FSM, target adder, flush counter and stats counter all live in the top module.
// TESTING
//  BEQ, compare_in=5'b10001, pc=0x0010, off=0x04 -> N+1 taken=1, redirect_pc=0x0015, flush=1.
//  BLT, compare_in=5'b01010 -> taken=0, br_ready stays 1; second request accepted at N+1.
//  JMP, pc=0xFFFE, off=0x01 -> redirect_pc=0x0000 (wrap). Next: pc=0x0005, off=0xFB -> 0x0001.
//  Taken branch, redirect_ready low 5 cycles -> redirect_pc stable, flush=1 throughout;
//   after ready, flush high 2 more cycles, then br_ready=1.
//  rst asserted during FLUSH -> next cycle all outputs 0, br_ready=1, taken_count=0.
//  Force taken_count=0xFFFE, issue 3 taken branches -> count stays at 0xFFFF.

Source files
------------

// File: rtl/branch_resolve_pkg.sv
// Shared definitions for the branch resolution block: condition codes,
// compare-flag bit positions and FSM state encodings.
package branch_resolve_pkg;

    localparam logic [2:0] COND_BEQ  = 3'd0;
    localparam logic [2:0] COND_BNE  = 3'd1;
    localparam logic [2:0] COND_BLT  = 3'd2;
    localparam logic [2:0] COND_BGT  = 3'd3;
    localparam logic [2:0] COND_BEQZ = 3'd4;
    localparam logic [2:0] COND_BLE  = 3'd5;
    localparam logic [2:0] COND_BGE  = 3'd6;
    localparam logic [2:0] COND_JMP  = 3'd7;

    localparam int CMP_EQ   = 4;
    localparam int CMP_NE   = 3;
    localparam int CMP_LT   = 2;
    localparam int CMP_GT   = 1;
    localparam int CMP_ZERO = 0;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_REDIRECT = 2'd1,
        ST_FLUSH    = 2'd2
    } state_e;

endpackage

// File: rtl/branch_cond_eval.sv
// Combinational evaluation of a branch condition code against the
// comparator flag bus {eq, ne, lt, gt, zero}.
module branch_cond_eval
    import branch_resolve_pkg::*;
(
    input  logic [2:0] cond_i,
    input  logic [4:0] flags_i,
    output logic       taken_o
);

    // Select the flag (or flag combination) named by the condition code
    always_comb begin
        taken_o = 1'b0;
        case (cond_i)
            COND_BEQ:  taken_o = flags_i[CMP_EQ];
            COND_BNE:  taken_o = flags_i[CMP_NE];
            COND_BLT:  taken_o = flags_i[CMP_LT];
            COND_BGT:  taken_o = flags_i[CMP_GT];
            COND_BEQZ: taken_o = flags_i[CMP_ZERO];
            COND_BLE:  taken_o = flags_i[CMP_EQ] | flags_i[CMP_LT];
            COND_BGE:  taken_o = flags_i[CMP_EQ] | flags_i[CMP_GT];
            COND_JMP:  taken_o = 1'b1;
            default:   taken_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_resolve.sv
// Branch resolution: decides taken/not-taken, computes the target PC,
// redirects fetch through a valid/ready handshake and then holds flush.
module branch_resolve
    import branch_resolve_pkg::*;
#(
    parameter int PC_W         = 16,
    parameter int OFF_W        = 8,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             br_valid,
    output logic             br_ready,
    input  logic [2:0]       br_cond,
    input  logic [PC_W-1:0]  br_pc,
    input  logic [OFF_W-1:0] br_offset,
    input  logic [4:0]       compare_in,
    output logic             resolved_valid,
    output logic             resolved_taken,
    output logic             redirect_valid,
    input  logic             redirect_ready,
    output logic [PC_W-1:0]  redirect_pc,
    output logic             flush,
    output logic [CNT_W-1:0] taken_count
);

    localparam int FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    state_e           state_q;
    logic             br_ready_q;
    logic             resolved_valid_q;
    logic             resolved_taken_q;
    logic             redirect_valid_q;
    logic [PC_W-1:0]  redirect_pc_q;
    logic             flush_q;
    logic [CNT_W-1:0] taken_count_q;
    logic [FC_W-1:0]  flush_cnt_q;

    logic             taken_s;
    logic [PC_W-1:0]  target_s;
    logic [CNT_W-1:0] taken_count_d;

    branch_cond_eval u_cond_eval (
        .cond_i  (br_cond),
        .flags_i (compare_in),
        .taken_o (taken_s)
    );

    // Offset is relative to the instruction after the branch; the sum wraps
    assign target_s = br_pc + PC_W'(1)
                    + {{(PC_W-OFF_W){br_offset[OFF_W-1]}}, br_offset};

    assign taken_count_d = (taken_count_q == '1) ? taken_count_q
                                                 : taken_count_q + CNT_W'(1);

    // Resolution FSM with all outputs held in registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= ST_IDLE;
            br_ready_q       <= 1'b1;
            resolved_valid_q <= 1'b0;
            resolved_taken_q <= 1'b0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
            flush_q          <= 1'b0;
            taken_count_q    <= '0;
            flush_cnt_q      <= '0;
        end else begin
            resolved_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (br_valid) begin
                        resolved_valid_q <= 1'b1;
                        resolved_taken_q <= taken_s;
                        if (taken_s) begin
                            state_q          <= ST_REDIRECT;
                            br_ready_q       <= 1'b0;
                            redirect_valid_q <= 1'b1;
                            redirect_pc_q    <= target_s;
                            flush_q          <= 1'b1;
                            taken_count_q    <= taken_count_d;
                        end
                    end
                end
                ST_REDIRECT: begin
                    if (redirect_ready) begin
                        state_q          <= ST_FLUSH;
                        redirect_valid_q <= 1'b0;
                        flush_cnt_q      <= FC_W'(FLUSH_CYCLES - 1);
                    end
                end
                ST_FLUSH: begin
                    if (flush_cnt_q == '0) begin
                        state_q    <= ST_IDLE;
                        br_ready_q <= 1'b1;
                        flush_q    <= 1'b0;
                    end else begin
                        flush_cnt_q <= flush_cnt_q - FC_W'(1);
                    end
                end
                default: begin
                    state_q          <= ST_IDLE;
                    br_ready_q       <= 1'b1;
                    redirect_valid_q <= 1'b0;
                    flush_q          <= 1'b0;
                end
            endcase
        end
    end

    assign br_ready       = br_ready_q;
    assign resolved_valid = resolved_valid_q;
    assign resolved_taken = resolved_taken_q;
    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;
    assign flush          = flush_q;
    assign taken_count    = taken_count_q;

endmodule

// File: tb/tb_branch_resolve.sv
// Directed self-checking bench for branch_resolve.
module tb_branch_resolve;

    logic        clk = 1'b0;
    logic        rst;
    logic        br_valid;
    logic        br_ready;
    logic [2:0]  br_cond;
    logic [15:0] br_pc;
    logic [7:0]  br_offset;
    logic [4:0]  compare_in;
    logic        resolved_valid;
    logic        resolved_taken;
    logic        redirect_valid;
    logic        redirect_ready;
    logic [15:0] redirect_pc;
    logic        flush;
    logic [15:0] taken_count;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] exp_cnt = 16'h0000;

    always #5 clk = ~clk;

    branch_resolve dut (
        .clk            (clk),
        .rst            (rst),
        .br_valid       (br_valid),
        .br_ready       (br_ready),
        .br_cond        (br_cond),
        .br_pc          (br_pc),
        .br_offset      (br_offset),
        .compare_in     (compare_in),
        .resolved_valid (resolved_valid),
        .resolved_taken (resolved_taken),
        .redirect_valid (redirect_valid),
        .redirect_ready (redirect_ready),
        .redirect_pc    (redirect_pc),
        .flush          (flush),
        .taken_count    (taken_count)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present one request for a single cycle and check the N+1 outputs
    task automatic issue(input logic [2:0] c, input logic [4:0] f, input logic [15:0] pc,
                         input logic [7:0] off, input logic exp_t, input logic [15:0] exp_pc);
        br_valid   = 1'b1;
        br_cond    = c;
        compare_in = f;
        br_pc      = pc;
        br_offset  = off;
        step();
        br_valid = 1'b0;
        chk("resolved_valid", {31'd0, resolved_valid}, 32'd1);
        chk("resolved_taken", {31'd0, resolved_taken}, {31'd0, exp_t});
        if (exp_t) begin
            exp_cnt = (exp_cnt == 16'hFFFF) ? exp_cnt : exp_cnt + 16'd1;
            chk("redirect_valid_t", {31'd0, redirect_valid}, 32'd1);
            chk("redirect_pc",      {16'd0, redirect_pc}, {16'd0, exp_pc});
            chk("flush_t",          {31'd0, flush}, 32'd1);
            chk("br_ready_t",       {31'd0, br_ready}, 32'd0);
            chk("taken_count",      {16'd0, taken_count}, {16'd0, exp_cnt});
        end else begin
            chk("redirect_valid_nt", {31'd0, redirect_valid}, 32'd0);
            chk("br_ready_nt",       {31'd0, br_ready}, 32'd1);
            chk("flush_nt",          {31'd0, flush}, 32'd0);
        end
    endtask

    // Complete the redirect handshake and walk the flush window back to IDLE
    task automatic drain();
        redirect_ready = 1'b1;
        step();
        redirect_ready = 1'b0;
        chk("drain_rv",     {31'd0, redirect_valid}, 32'd0);
        chk("drain_flush1", {31'd0, flush}, 32'd1);
        step();
        chk("drain_flush2", {31'd0, flush}, 32'd1);
        chk("drain_busy",   {31'd0, br_ready}, 32'd0);
        step();
        chk("drain_flush0", {31'd0, flush}, 32'd0);
        chk("drain_ready",  {31'd0, br_ready}, 32'd1);
    endtask

    initial begin
        rst            = 1'b1;
        br_valid       = 1'b0;
        br_cond        = 3'd0;
        br_pc          = 16'h0000;
        br_offset      = 8'h00;
        compare_in     = 5'b00000;
        redirect_ready = 1'b0;
        step();
        step();
        rst = 1'b0;
        chk("rst_ready", {31'd0, br_ready}, 32'd1);
        chk("rst_rv",    {31'd0, resolved_valid}, 32'd0);
        chk("rst_rt",    {31'd0, resolved_taken}, 32'd0);
        chk("rst_dv",    {31'd0, redirect_valid}, 32'd0);
        chk("rst_pc",    {16'd0, redirect_pc}, 32'd0);
        chk("rst_flush", {31'd0, flush}, 32'd0);
        chk("rst_cnt",   {16'd0, taken_count}, 32'd0);

        // BEQ taken: 0x10 + 1 + 4
        issue(3'd0, 5'b10001, 16'h0010, 8'h04, 1'b1, 16'h0015);
        drain();
        chk("pulse_one_cycle", {31'd0, resolved_valid}, 32'd0);

        // BLT not taken, then BGT taken accepted on the very next cycle
        br_valid   = 1'b1;
        br_cond    = 3'd2;
        compare_in = 5'b01010;
        br_pc      = 16'h0020;
        br_offset  = 8'h08;
        step();
        chk("blt_rv",    {31'd0, resolved_valid}, 32'd1);
        chk("blt_taken", {31'd0, resolved_taken}, 32'd0);
        chk("blt_ready", {31'd0, br_ready}, 32'd1);
        br_cond   = 3'd3;
        br_pc     = 16'h0100;
        br_offset = 8'h10;
        step();
        exp_cnt = exp_cnt + 16'd1;
        chk("bgt_rv",    {31'd0, resolved_valid}, 32'd1);
        chk("bgt_taken", {31'd0, resolved_taken}, 32'd1);
        chk("bgt_pc",    {16'd0, redirect_pc}, 32'h0111);
        chk("bgt_cnt",   {16'd0, taken_count}, {16'd0, exp_cnt});

        // Fetch stalls 5 cycles while a new request is held and must be ignored
        br_pc     = 16'h0200;
        br_offset = 8'h22;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("stall_pc",    {16'd0, redirect_pc}, 32'h0111);
            chk("stall_dv",    {31'd0, redirect_valid}, 32'd1);
            chk("stall_flush", {31'd0, flush}, 32'd1);
            chk("stall_busy",  {31'd0, br_ready}, 32'd0);
            chk("stall_rv",    {31'd0, resolved_valid}, 32'd0);
        end
        br_valid = 1'b0;
        drain();

        // JMP with PC wrap in both directions
        issue(3'd7, 5'b00000, 16'hFFFE, 8'h01, 1'b1, 16'h0000);
        drain();
        issue(3'd7, 5'b00000, 16'h0005, 8'hFB, 1'b1, 16'h0001);
        drain();

        // Remaining condition codes
        issue(3'd4, 5'b00001, 16'h0030, 8'h02, 1'b1, 16'h0033);
        drain();
        issue(3'd5, 5'b00100, 16'h0040, 8'hF0, 1'b1, 16'h0031);
        drain();
        issue(3'd6, 5'b00100, 16'h0050, 8'h01, 1'b0, 16'h0000);
        issue(3'd1, 5'b10000, 16'h0060, 8'h01, 1'b0, 16'h0000);
        issue(3'd1, 5'b01000, 16'h0060, 8'h01, 1'b1, 16'h0062);
        drain();

        // Reset in the middle of the flush window
        issue(3'd7, 5'b00000, 16'h0070, 8'h00, 1'b1, 16'h0071);
        redirect_ready = 1'b1;
        step();
        redirect_ready = 1'b0;
        chk("pre_rst_flush", {31'd0, flush}, 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        exp_cnt = 16'h0000;
        chk("mid_rst_ready", {31'd0, br_ready}, 32'd1);
        chk("mid_rst_flush", {31'd0, flush}, 32'd0);
        chk("mid_rst_dv",    {31'd0, redirect_valid}, 32'd0);
        chk("mid_rst_pc",    {16'd0, redirect_pc}, 32'd0);
        chk("mid_rst_cnt",   {16'd0, taken_count}, 32'd0);
        chk("mid_rst_rv",    {31'd0, resolved_valid}, 32'd0);

        // Saturation of the taken counter
        force dut.taken_count_q = 16'hFFFE;
        #1;
        release dut.taken_count_q;
        step();
        exp_cnt = 16'hFFFE;
        chk("forced_cnt", {16'd0, taken_count}, 32'h0000FFFE);
        for (int k = 0; k < 3; k++) begin
            issue(3'd7, 5'b00000, 16'h0080, 8'h00, 1'b1, 16'h0081);
            drain();
        end
        chk("sat_cnt", {16'd0, taken_count}, 32'h0000FFFF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
